dbg_trace_fifo: RTL and testbench

- Downstream debug consumer of the cpu debug interface.
- Captures regfile write-back events and RAM write events, each tagged with the current PC, into a circular buffer.
- A software-less bench or host drains the buffer through a valid/ready port.
- An arm/trigger FSM allows capture to start at a chosen PC and stop after a programmed number of entries.

---
 rtl/dbg_pkg.sv | 29 ++
 rtl/dbg_trace_fifo_if.sv | 12 +
 rtl/trace_ram2w.sv | 36 +++
 rtl/dbg_trace_fifo.sv | 159 +++++++++++++++
 tb/tb_dbg_trace_fifo.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug trace buffer: record kinds, FSM encodings
// and the bit layout of a trace record {kind, pc, addr, data}.
package dbg_pkg;

  localparam logic [1:0] KIND_REG = 2'b01;
  localparam logic [1:0] KIND_RAM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int REC_DATA_LSB = 0;
  localparam int REC_DATA_W   = 16;
  localparam int REC_ADDR_LSB = 16;
  localparam int REC_ADDR_W   = 8;
  localparam int REC_PC_LSB   = 24;

  function automatic int rec_kind_lsb(input int pc_w);
    return REC_PC_LSB + pc_w;
  endfunction

  function automatic int rec_width(input int pc_w);
    return rec_kind_lsb(pc_w) + 2;
  endfunction

endpackage

// File: rtl/dbg_trace_fifo_if.sv
// Read-side handshake of the trace buffer: the buffer is master, the
// draining host is slave.
interface dbg_trace_fifo_if #(
  parameter int REC_W = 34
);
  logic             out_valid;
  logic             out_ready;
  logic [REC_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/trace_ram2w.sv
// Trace storage: register array with two write ports on consecutive
// addresses (waddr, waddr+1) and one asynchronous read port.
module trace_ram2w #(
  parameter int DEPTH = 16,
  parameter int REC_W = 34,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr,
  input  logic [REC_W-1:0] wdata0,
  input  logic [REC_W-1:0] wdata1,
  input  logic [AW-1:0]    raddr,
  output logic [REC_W-1:0] rdata
);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    waddr1;

  assign waddr1 = waddr + AW'(1);

  // The two ports never target the same entry, so the priority is moot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (we0 && (waddr == AW'(gi))) begin
        mem[gi] <= wdata0;
      end else if (we1 && (waddr1 == AW'(gi))) begin
        mem[gi] <= wdata1;
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dbg_trace_fifo.sv
// Debug trace buffer: captures regfile and RAM write events tagged with the
// PC, under an arm/trigger/stop FSM, and drains them through valid/ready.
module dbg_trace_fifo
  import dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 8,
  parameter int REC_W = 2 + PC_W + 8 + 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_arm,
  input  logic                cfg_trig_en,
  input  logic [PC_W-1:0]     cfg_trig_pc,
  input  logic [7:0]          cfg_stop_len,
  input  logic [PC_W-1:0]     trc_pc,
  input  logic                trc_wr_rd,
  input  logic [3:0]          trc_addr_rd,
  input  logic [15:0]         trc_wdata_rd,
  input  logic                trc_ram_wr,
  input  logic [7:0]          trc_ram_waddr,
  input  logic [15:0]         trc_ram_wdata,
  dbg_trace_fifo_if.master    out_if,
  output logic [LW-1:0]       level,
  output logic [1:0]          state,
  output logic                overflow,
  output logic [7:0]          drop_cnt
);

  state_t          state_reg, state_next;
  logic            trig_en_reg;
  logic [PC_W-1:0] trig_pc_reg;
  logic [7:0]      stop_len_reg;
  logic [7:0]      cap_cnt_reg, cap_cnt_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg, level_next;
  logic            overflow_reg;
  logic [7:0]      drop_cnt_reg, drop_cnt_next;

  logic             pop, trig_hit, capture_en, want_reg, want_ram;
  logic             acc_reg, acc_ram, ovf_reg, ovf_ram, stop_hit;
  logic [LW-1:0]    free_slots;
  logic [7:0]       budget_left;
  logic [1:0]       space_avail, budget_avail, slots, ram_pos, n_push, n_ovf;
  logic [8:0]       cap_sum, drop_sum;
  logic [REC_W-1:0] rec_reg, rec_ram, rd_rec;

  assign out_if.out_valid = (level_reg != '0);
  assign out_if.out_data  = out_if.out_valid ? rd_rec : '0;
  assign pop              = out_if.out_valid & out_if.out_ready;

  // An arm pulse restarts the session, so that cycle captures nothing.
  assign trig_hit   = (state_reg == ST_ARMED) && (trc_pc == trig_pc_reg);
  assign capture_en = !cfg_arm && ((state_reg == ST_CAPTURE) || trig_hit);
  assign want_reg   = capture_en && trc_wr_rd;
  assign want_ram   = capture_en && trc_ram_wr;

  assign free_slots   = LW'(DEPTH) - level_reg + LW'(pop);
  assign space_avail  = (free_slots >= LW'(2)) ? 2'd2 : free_slots[1:0];
  assign budget_left  = stop_len_reg - cap_cnt_reg;
  assign budget_avail = ((stop_len_reg == 8'd0) || (budget_left >= 8'd2)) ? 2'd2 : budget_left[1:0];
  assign slots        = (space_avail < budget_avail) ? space_avail : budget_avail;

  // The RAM record sits behind the regfile record when both fire.
  assign ram_pos = want_reg ? 2'd2 : 2'd1;
  assign acc_reg = want_reg && (slots >= 2'd1);
  assign acc_ram = want_ram && (slots >= ram_pos);
  // Only a rejection that the stop budget would have allowed counts as overflow.
  assign ovf_reg = want_reg && (space_avail == 2'd0) && (budget_avail != 2'd0);
  assign ovf_ram = want_ram && (space_avail < ram_pos) && (budget_avail >= ram_pos);
  assign n_push  = {1'b0, acc_reg} + {1'b0, acc_ram};
  assign n_ovf   = {1'b0, ovf_reg} + {1'b0, ovf_ram};

  assign cap_sum  = {1'b0, cap_cnt_reg} + {7'd0, n_push};
  assign stop_hit = (stop_len_reg != 8'd0) && (cap_sum >= {1'b0, stop_len_reg});
  assign drop_sum = {1'b0, drop_cnt_reg} + {7'd0, n_ovf};

  assign rec_reg = {KIND_REG, trc_pc, 4'b0000, trc_addr_rd, trc_wdata_rd};
  assign rec_ram = {KIND_RAM, trc_pc, trc_ram_waddr, trc_ram_wdata};

  trace_ram2w #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ram (
    .clk    (clk),
    .we0    (acc_reg | acc_ram),
    .we1    (acc_reg & acc_ram),
    .waddr  (wr_ptr_reg),
    .wdata0 (acc_reg ? rec_reg : rec_ram),
    .wdata1 (rec_ram),
    .raddr  (rd_ptr_reg),
    .rdata  (rd_rec)
  );

  always_comb begin
    state_next = state_reg;
    if (cfg_arm) begin
      state_next = cfg_trig_en ? ST_ARMED : ST_CAPTURE;
    end else begin
      case (state_reg)
        ST_ARMED:   if (trig_hit) state_next = stop_hit ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE: if (stop_hit) state_next = ST_DONE;
        default:    state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    level_next    = level_reg + LW'(n_push) - LW'(pop);
    cap_cnt_next  = cap_sum[8] ? 8'hFF : cap_sum[7:0];
    drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_en_reg  <= 1'b0;
      trig_pc_reg  <= '0;
      stop_len_reg <= 8'd0;
      cap_cnt_reg  <= 8'd0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(n_push);
      rd_ptr_reg <= rd_ptr_reg + AW'(pop);
      level_reg  <= level_next;
      if (cfg_arm) begin
        trig_en_reg  <= cfg_trig_en;
        trig_pc_reg  <= cfg_trig_pc;
        stop_len_reg <= cfg_stop_len;
        cap_cnt_reg  <= 8'd0;
        overflow_reg <= 1'b0;
        drop_cnt_reg <= 8'd0;
      end else begin
        cap_cnt_reg  <= cap_cnt_next;
        drop_cnt_reg <= drop_cnt_next;
        if (n_ovf != 2'd0) overflow_reg <= 1'b1;
      end
    end
  end

  assign level    = level_reg;
  assign state    = state_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_dbg_trace_fifo.sv
// Directed bench for dbg_trace_fifo: stimulus pushes expected records into a
// queue, a monitor compares every popped record against it.
module tb_dbg_trace_fifo;

  localparam int DEPTH = 16;
  localparam int PC_W  = 8;
  localparam int REC_W = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_arm = 1'b0;
  logic        cfg_trig_en = 1'b0;
  logic [7:0]  cfg_trig_pc = 8'd0;
  logic [7:0]  cfg_stop_len = 8'd0;
  logic [7:0]  trc_pc = 8'd0;
  logic        trc_wr_rd = 1'b0;
  logic [3:0]  trc_addr_rd = 4'd0;
  logic [15:0] trc_wdata_rd = 16'd0;
  logic        trc_ram_wr = 1'b0;
  logic [7:0]  trc_ram_waddr = 8'd0;
  logic [15:0] trc_ram_wdata = 16'd0;
  logic [4:0]  level;
  logic [1:0]  state;
  logic        overflow;
  logic [7:0]  drop_cnt;

  dbg_trace_fifo_if #(.REC_W(REC_W)) oif ();

  dbg_trace_fifo #(.DEPTH(DEPTH), .PC_W(PC_W), .REC_W(REC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_arm       (cfg_arm),
    .cfg_trig_en   (cfg_trig_en),
    .cfg_trig_pc   (cfg_trig_pc),
    .cfg_stop_len  (cfg_stop_len),
    .trc_pc        (trc_pc),
    .trc_wr_rd     (trc_wr_rd),
    .trc_addr_rd   (trc_addr_rd),
    .trc_wdata_rd  (trc_wdata_rd),
    .trc_ram_wr    (trc_ram_wr),
    .trc_ram_waddr (trc_ram_waddr),
    .trc_ram_wdata (trc_ram_wdata),
    .out_if        (oif),
    .level         (level),
    .state         (state),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [REC_W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [REC_W-1:0] rec(input logic [1:0] kind, input logic [7:0] pc,
                                           input logic [7:0] addr, input logic [15:0] data);
    return {kind, pc, addr, data};
  endfunction

  // Monitor: every accepted pop must match the oldest expected record.
  initial begin
    logic [REC_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && oif.out_valid && oif.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(oif.out_data), 64'h0);
          if (oif.out_data == '0) begin
            failures++;
            $display("FAIL unexpected_pop: got empty scoreboard, required no pop");
          end
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 64'(oif.out_data), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic te, input logic [7:0] tpc, input logic [7:0] slen);
    cfg_arm = 1'b1; cfg_trig_en = te; cfg_trig_pc = tpc; cfg_stop_len = slen;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic ev(input logic [7:0] pc, input logic wr, input logic [3:0] rd, input logic [15:0] wd,
                    input logic rw, input logic [7:0] ra, input logic [15:0] rdat,
                    input logic exp_reg, input logic exp_ram);
    trc_pc = pc; trc_wr_rd = wr; trc_addr_rd = rd; trc_wdata_rd = wd;
    trc_ram_wr = rw; trc_ram_waddr = ra; trc_ram_wdata = rdat;
    if (exp_reg) exp_q.push_back(rec(2'b01, pc, {4'b0, rd}, wd));
    if (exp_ram) exp_q.push_back(rec(2'b10, pc, ra, rdat));
    tick();
    trc_wr_rd = 1'b0; trc_ram_wr = 1'b0;
  endtask

  task automatic drain();
    oif.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!oif.out_valid) break;
      tick();
    end
    oif.out_ready = 1'b0;
    chk("drain_empty", 64'(oif.out_valid), 64'd0);
  endtask

  initial begin
    oif.out_ready = 1'b0;
    tick(); tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(oif.out_valid), 64'd0);
    chk("rst_data", 64'(oif.out_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // Single regfile write, free-running capture.
    arm(1'b0, 8'h00, 8'd0);
    chk("arm_capture", 64'(state), 64'd2);
    ev(8'h05, 1'b1, 4'd3, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    chk("single_valid", 64'(oif.out_valid), 64'd1);
    chk("single_level", 64'(level), 64'd1);
    chk("single_data", 64'(oif.out_data), 64'h1_0503_1234);
    drain();

    // Simultaneous regfile and RAM write: regfile first.
    ev(8'h06, 1'b1, 4'd7, 16'h5555, 1'b1, 8'h20, 16'hBEEF, 1'b1, 1'b1);
    chk("dual_level", 64'(level), 64'd2);
    drain();

    // Trigger on pc 8'h10; earlier events ignored.
    arm(1'b1, 8'h10, 8'd0);
    chk("armed_state", 64'(state), 64'd1);
    ev(8'h0E, 1'b1, 4'd2, 16'h0E0E, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    ev(8'h0F, 1'b0, 4'd0, 16'h0000, 1'b1, 8'h44, 16'h0F0F, 1'b0, 1'b0);
    chk("pretrig_level", 64'(level), 64'd0);
    chk("pretrig_state", 64'(state), 64'd1);
    ev(8'h10, 1'b1, 4'd1, 16'h0A0A, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    chk("trig_state", 64'(state), 64'd2);
    chk("trig_level", 64'(level), 64'd1);
    drain();

    // Stop after 3 entries.
    arm(1'b0, 8'h00, 8'd3);
    for (int i = 0; i < 5; i++) begin
      ev(8'(8'h30 + i), 1'b1, 4'(i), 16'(16'hA000 + i), 1'b0, 8'h00, 16'h0000, i < 3, 1'b0);
      if (i == 2) chk("stop_done", 64'(state), 64'd3);
    end
    chk("stop_level", 64'(level), 64'd3);
    chk("stop_ovf", 64'(overflow), 64'd0);
    chk("stop_drop", 64'(drop_cnt), 64'd0);
    drain();

    // One budget unit with both events: regfile kept, RAM dropped without overflow.
    arm(1'b0, 8'h00, 8'd1);
    ev(8'h40, 1'b1, 4'd9, 16'h9999, 1'b1, 8'h41, 16'h4141, 1'b1, 1'b0);
    chk("budget_state", 64'(state), 64'd3);
    chk("budget_level", 64'(level), 64'd1);
    chk("budget_ovf", 64'(overflow), 64'd0);
    drain();

    // Fill past capacity.
    arm(1'b0, 8'h00, 8'd0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      ev(8'(8'h50 + i), 1'b1, 4'(i), 16'(16'hC000 + i), 1'b0, 8'h00, 16'h0000, i < DEPTH, 1'b0);
    end
    chk("full_level", 64'(level), 64'd16);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_drop", 64'(drop_cnt), 64'd2);
    // Pop and push in the same cycle on a full buffer.
    oif.out_ready = 1'b1;
    ev(8'h70, 1'b1, 4'd5, 16'hD00D, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    oif.out_ready = 1'b0;
    chk("popush_level", 64'(level), 64'd16);
    chk("popush_drop", 64'(drop_cnt), 64'd2);
    // One free slot with both events: RAM record overflows.
    oif.out_ready = 1'b1;
    ev(8'h71, 1'b1, 4'd6, 16'hD11D, 1'b1, 8'h72, 16'h7272, 1'b1, 1'b0);
    oif.out_ready = 1'b0;
    chk("one_slot_level", 64'(level), 64'd16);
    chk("one_slot_drop", 64'(drop_cnt), 64'd3);
    drain();

    // Arm clears overflow state; reset mid-capture discards the buffer.
    arm(1'b0, 8'h00, 8'd0);
    chk("rearm_ovf", 64'(overflow), 64'd0);
    chk("rearm_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      ev(8'(8'h80 + i), 1'b1, 4'(i), 16'(16'hE000 + i), 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    end
    chk("pre_rst_level", 64'(level), 64'd5);
    chk("pre_rst_state", 64'(state), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_valid", 64'(oif.out_valid), 64'd0);
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
